psum_drain: RTL and testbench
=============================

# psum_drain

Downstream collector for one PE column. It detects the rising edge of the top PE's `complete`, then samples the `opsum` burst of P partial sums. Across `npass` channel passes it accumulates those sums into a local buffer. After the final pass it streams the finished psums to the global buffer over a valid/ready handshake. It sits between the top PE of the column and the global-buffer write port.

## Interface
Parameters:
- `DW`, 16, psum width; must equal PE `opsum` width.
- `PMAX`, 24, accumulator buffer depth; the maximum legal P.
- `CAP_DLY`, 2, cycles from the rising-edge detect cycle to the first sample; ≥1.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `P` in 5: psums per burst; legal 1..PMAX.
- `npass` in 4: passes to accumulate before drain; 0 is treated as 1.
- `complete` in 1: level from the top PE of the column.
- `opsum` in DW: psum stream from the top PE.
- `flush` in 1: synchronous abort and clear.
- `out_data` out DW: psum word to the global buffer.
- `out_idx` out 5: buffer index of `out_data`.
- `out_valid` out 1: `out_data`/`out_idx` are valid.
- `out_ready` in 1: global buffer accepts the current word.
- `busy` out 1: state ≠ IDLE or pass_cnt ≠ 0.
- `done` out 1: one-cycle pulse after the last drain handshake.
- `err` out 1: sticky protocol error.

## Operation
Edge detect:
- `cmp_q` registers `complete`.
- An edge is `complete & ~cmp_q`, evaluated every cycle.

States:
- **IDLE**
  - On edge: if P∈[1,PMAX], latch P into `p_l` (first pass only; later passes use `p_l`), load `dly_cnt`=CAP_DLY−1, go to DELAY.
  - On edge with P illegal: set `err`, stay in IDLE.
- **DELAY**
  - Decrement `dly_cnt`.
  - At 0, go to CAPTURE with `idx`=0.
- **CAPTURE**
  - Each cycle sample `opsum` into entry `idx`, then `idx`++.
  - Pass 0 writes `acc[idx]=opsum`. Later passes write `acc[idx]=acc[idx]+opsum`, modulo 2^DW (wrap, no saturation).
  - After sampling `idx`=`p_l`−1: `pass_cnt`++.
  - If `pass_cnt`+1 == max(npass,1), go to DRAIN with `idx`=0. Otherwise go to IDLE.
- **DRAIN**
  - `out_valid`=1, `out_data`=`acc[idx]`, `out_idx`=`idx`.
  - On `out_valid & out_ready`: `idx`++.
  - On the handshake at `idx`=`p_l`−1: go to IDLE, clear `pass_cnt`, pulse `done` next cycle.

Error and boundary cases:
- An edge seen in DELAY, CAPTURE or DRAIN is ignored and sets `err`.
- This includes an edge on the same cycle as the final drain handshake.
- `npass` is sampled at the end of every capture. Changing it mid-accumulation is legal; the new value takes effect at the next check.
- `flush` (priority below `rst_n`, above everything else):
  - go to IDLE; `pass_cnt`=0, `idx`=0, `err`=0;
  - `out_valid`=0, `done`=0;
  - `acc` contents are don't-care.

## Timing
- Reset values (cycle after `rst_n` low): state IDLE, `out_valid`=0, `out_data`=0, `out_idx`=0, `busy`=0, `done`=0, `err`=0, `pass_cnt`=0, `cmp_q`=0.
  - `acc` is not reset; pass 0 overwrites it.
- Reset or flush mid-CAPTURE or mid-DRAIN abandons the accumulation. `out_valid` is low the next cycle.
- Capture timing:
  - Edge detected at cycle t means `complete` was high at t and `cmp_q` low.
  - Sample k (k=0..p_l−1) is taken at posedge t+CAP_DLY+k.
  - There are no gaps and no backpressure toward the PE.
- Drain timing:
  - `out_valid` rises in the cycle after the last sample of the final pass.
  - `out_data` and `out_idx` hold stable while `out_valid & ~out_ready`.
  - Throughput is one word per cycle when `out_ready`=1.
  - Minimum drain latency is `p_l` cycles. `done` goes high the cycle after the last handshake, for exactly 1 cycle.
- `busy` is registered and stays high for the whole accumulation, including IDLE between passes.
- The earliest accepted next-pass edge is the cycle the state returns to IDLE.

## Structure
- Shared package `pe_pkg`:
  - `DW`, `PMAX`;
  - the state enum `drain_state_t` {IDLE, DELAY, CAPTURE, DRAIN};
  - widths for P (5) and Q/npass (4).
- Sub-module `psum_acc_buf`: PMAX×DW register file with one read and one write port. The read is combinational, so read-modify-write completes in one cycle. The FSM, counters and edge detect stay in `psum_drain`.

## Test plan
- **Single pass:** P=4, npass=1, CAP_DLY=2, `opsum`=10,20,30,40 from t+2; `out_ready`=1 → `out_data` 10,20,30,40 with `out_idx` 0..3, then `done` one cycle later.
- **Accumulate:** P=3, npass=2. Pass 1 sums 1,2,3; pass 2 sums 100,200,0xFFFF → drain 101, 202, 0x0002 (wrap).
- **Backpressure:** P=2, npass=1, `out_ready` low for 3 cycles at idx 0 → `out_data` held at word 0 for 4 cycles. `done` asserts only after the idx-1 handshake.
- **Protocol errors:** rising `complete` during CAPTURE → `err`=1, samples unaffected. P=0 or P=25 at an IDLE edge → `err`=1, state stays IDLE, `busy`=0.
- **Flush:** flush mid-DRAIN at idx 1 → `out_valid`=0 next cycle, `err`=0. A new burst of P=2 (5,6) then drains 5,6.
- **Reset:** `rst_n` low mid-CAPTURE with `complete` still high → all outputs at reset values. No spurious edge while `complete` stays high; an edge is accepted only after `complete` falls and rises again.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and types for the PE column collector.
//   DW    : psum width (matches PE opsum)
//   PMAX  : accumulator depth, largest legal burst length P
//   PW/QW : widths of the P and npass fields
package pe_pkg;

   localparam int unsigned DW   = 16;
   localparam int unsigned PMAX = 24;
   localparam int unsigned PW   = 5;
   localparam int unsigned QW   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      CAPTURE = 2'd2,
      DRAIN   = 2'd3
   } drain_state_t;

endpackage

// File: rtl/psum_acc_buf.sv
// Psum accumulator register file: one synchronous write port, one
// combinational read port so a read-modify-write fits in one cycle.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port; out-of-range addresses read as zero
module psum_acc_buf #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 24,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Contents need no reset: the first pass overwrites every used entry.
   always_ff @(posedge clk) begin
      if (we && (32'(waddr) < DEPTH)) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      if (32'(raddr) < DEPTH) begin
         rdata = mem[raddr];
      end
   end

endmodule

// File: rtl/psum_drain.sv
// Downstream collector for one PE column. Detects a rising edge of the
// top PE's complete, captures a P-word opsum burst CAP_DLY cycles later,
// accumulates npass bursts, then streams the sums out over valid/ready.
//   clk, rst_n (sync, active-low), flush (sync abort/clear)
//   P, npass            : burst length and pass count
//   complete, opsum     : level and data stream from the top PE
//   out_data/out_idx/out_valid/out_ready : drain handshake
//   busy, done, err     : status (done is a 1-cycle pulse, err sticky)
module psum_drain #(
   parameter int unsigned DW      = pe_pkg::DW,
   parameter int unsigned PMAX    = pe_pkg::PMAX,
   parameter int unsigned CAP_DLY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [pe_pkg::PW-1:0] P,
   input  logic [pe_pkg::QW-1:0] npass,
   input  logic                  complete,
   input  logic [DW-1:0]         opsum,
   input  logic                  flush,
   output logic [DW-1:0]         out_data,
   output logic [pe_pkg::PW-1:0] out_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   import pe_pkg::*;

   localparam int unsigned DLY_W = (CAP_DLY > 1) ? $clog2(CAP_DLY) : 1;
   localparam int unsigned QW1   = QW + 1;

   drain_state_t   state;
   logic           cmp_q;
   logic           low_seen;
   logic [PW-1:0]  p_l;
   logic [PW-1:0]  idx;
   logic [QW-1:0]  pass_cnt;
   logic [DLY_W-1:0] dly_cnt;
   logic [DW-1:0]  head_q;

   logic           edge_c;
   logic           p_ok_c;
   logic           last_c;
   logic           final_c;
   logic           hs_c;
   logic [QW-1:0]  npass_eff_c;
   logic [PW-1:0]  rd_addr_c;
   logic [DW-1:0]  rd_data_c;
   logic [DW-1:0]  wr_data_c;

   // A level still high across reset must not look like a new burst, so a
   // rise only counts once complete has been seen low since reset.
   assign edge_c      = complete & ~cmp_q & low_seen;
   assign p_ok_c      = (P != '0) && (32'(P) <= PMAX);
   assign last_c      = (idx == p_l - PW'(1));
   assign hs_c        = out_valid & out_ready;
   assign npass_eff_c = (npass == '0) ? QW'(1) : npass;
   assign final_c     = ((QW1'(pass_cnt) + QW1'(1)) == QW1'(npass_eff_c));

   // Capture reads the entry being updated; drain prefetches the next word.
   assign rd_addr_c = (state == DRAIN) ? idx + PW'(1) : idx;
   assign wr_data_c = (pass_cnt == '0) ? opsum : DW'(rd_data_c + opsum);

   psum_acc_buf #(
      .DW    (DW),
      .DEPTH (PMAX),
      .AW    (PW)
   ) u_buf (
      .clk   (clk),
      .we    (state == CAPTURE),
      .waddr (idx),
      .wdata (wr_data_c),
      .raddr (rd_addr_c),
      .rdata (rd_data_c)
   );

   // Control FSM, counters, edge detect and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmp_q     <= 1'b0;
         low_seen  <= ~complete;
         p_l       <= '0;
         idx       <= '0;
         pass_cnt  <= '0;
         dly_cnt   <= '0;
         head_q    <= '0;
         out_data  <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         cmp_q     <= complete;
         low_seen  <= low_seen | ~complete;
         idx       <= '0;
         pass_cnt  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         cmp_q    <= complete;
         low_seen <= low_seen | ~complete;
         done     <= 1'b0;
         if (edge_c && (state != IDLE)) begin
            err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (edge_c) begin
                  if (p_ok_c) begin
                     if (pass_cnt == '0) begin
                        p_l <= P;
                     end
                     busy <= 1'b1;
                     idx  <= '0;
                     // A one-cycle delay leaves no room for DELAY at all.
                     if (CAP_DLY == 1) begin
                        state <= CAPTURE;
                     end else begin
                        state   <= DELAY;
                        dly_cnt <= DLY_W'(CAP_DLY - 1);
                     end
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            DELAY: begin
               dly_cnt <= dly_cnt - DLY_W'(1);
               if (dly_cnt == DLY_W'(1)) begin
                  state <= CAPTURE;
                  idx   <= '0;
               end
            end
            CAPTURE: begin
               idx <= idx + PW'(1);
               // Word 0 is kept aside so the drain can start without a
               // second read port while the last entry is being written.
               if (idx == '0) begin
                  head_q <= wr_data_c;
               end
               if (last_c) begin
                  pass_cnt <= pass_cnt + QW'(1);
                  idx      <= '0;
                  if (final_c) begin
                     state     <= DRAIN;
                     out_valid <= 1'b1;
                     out_idx   <= '0;
                     out_data  <= (idx == '0) ? wr_data_c : head_q;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DRAIN: begin
               if (hs_c) begin
                  if (last_c) begin
                     state     <= IDLE;
                     idx       <= '0;
                     pass_cnt  <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     idx      <= idx + PW'(1);
                     out_idx  <= idx + PW'(1);
                     out_data <= rd_data_c;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: directed scenarios plus randomized
// bursts checked against a pass-accumulating reference model.
module tb_psum_drain;

   localparam int unsigned CAP_DLY = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  P;
   logic [3:0]  npass;
   logic        complete;
   logic [15:0] opsum;
   logic        flush;
   logic [15:0] out_data;
   logic [4:0]  out_idx;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   psum_drain #(.CAP_DLY(CAP_DLY)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .P         (P),
      .npass     (npass),
      .complete  (complete),
      .opsum     (opsum),
      .flush     (flush),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [4:0]  idx;
      logic        last;
   } exp_t;

   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q[$];
   logic [15:0] macc [24];
   logic [15:0] wbuf [24];
   int          mpass = 0;
   bit          exp_err = 0;
   int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
   bit          mon_en = 0;
   bit          done_due = 0;
   bit          prev_stall = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   function automatic logic pick_ready();
      if (ready_mode == 1) return ($urandom_range(0, 3) != 0);
      if (ready_mode == 2) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      mpass   = 0;
      exp_err = 0;
   endtask

   // Drain monitor: every valid word must match the head of the expected
   // queue, stalled words must stay valid, done follows the last handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("done", 32'(done), 32'(done_due));
         if (!rst_n || flush) begin
            done_due   = 0;
            prev_stall = 0;
         end else begin
            if (prev_stall) chk("hold_valid", 32'(out_valid), 32'(1));
            done_due = 0;
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("valid_extra", 32'(out_valid), 32'(0));
               end else begin
                  chk("drain_data", 32'(out_data), 32'(exp_q[0].data));
                  chk("drain_idx", 32'(out_idx), 32'(exp_q[0].idx));
                  if (out_ready) begin
                     done_due = exp_q[0].last;
                     void'(exp_q.pop_front());
                  end
               end
            end
            prev_stall = out_valid && !out_ready;
         end
      end
   end

   // One pass: rising complete, CAP_DLY cycles, then p words back to back.
   task automatic send_burst(input int p, input int np, input int glitch);
      int npe;
      bit fin;
      P        = 5'(p);
      npass    = 4'(np);
      complete = 1'b1;
      opsum    = 16'($urandom);
      repeat (CAP_DLY) begin
         @(posedge clk); #1;
         out_ready = pick_ready();
      end
      for (int k = 0; k < p; k++) begin
         opsum = wbuf[k];
         if (k == glitch) complete = 1'b0;
         else if (k == glitch + 1) complete = 1'b1;
         @(posedge clk); #1;
         out_ready = pick_ready();
      end
      opsum = 16'($urandom);
      if (glitch >= 0 && glitch + 1 < p) exp_err = 1;
      for (int i = 0; i < p; i++)
         macc[i] = (mpass == 0) ? wbuf[i] : 16'(macc[i] + wbuf[i]);
      mpass++;
      npe = (np == 0) ? 1 : np;
      fin = (mpass == npe);
      if (fin) begin
         for (int i = 0; i < p; i++)
            exp_q.push_back('{data: macc[i], idx: 5'(i), last: (i == p - 1)});
         mpass = 0;
         chk("valid_rise", 32'(out_valid), 32'(1));
         chk("first_word", 32'(out_data), 32'(exp_q[0].data));
         chk("first_idx", 32'(out_idx), 32'(0));
      end else begin
         chk("between_busy", 32'(busy), 32'(1));
         chk("between_valid", 32'(out_valid), 32'(0));
      end
      chk("err_after_burst", 32'(err), 32'(exp_err));
      complete = 1'b0;
      @(posedge clk); #1;
      out_ready = pick_ready();
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 400; c++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         @(posedge clk); #1;
         out_ready = pick_ready();
      end
      chk("drain_left", 32'(exp_q.size()), 32'(0));
      chk("drain_valid_low", 32'(out_valid), 32'(0));
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'(0));
   endtask

   task automatic pulse_edge(input int p);
      P        = 5'(p);
      complete = 1'b1;
      @(posedge clk); #1;
      complete = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      model_clear();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'(0));
      chk({tag, "_data"},  32'(out_data),  32'(0));
      chk({tag, "_idx"},   32'(out_idx),   32'(0));
      chk({tag, "_busy"},  32'(busy),      32'(0));
      chk({tag, "_done"},  32'(done),      32'(0));
      chk({tag, "_err"},   32'(err),       32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; P = '0; npass = '0; complete = 1'b0;
      opsum = '0; flush = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      mon_en = 1;
      @(posedge clk); #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single pass
      wbuf[0] = 16'd10; wbuf[1] = 16'd20; wbuf[2] = 16'd30; wbuf[3] = 16'd40;
      send_burst(4, 1, -1);
      wait_drain();

      // Two-pass accumulate with wrap
      wbuf[0] = 16'd1; wbuf[1] = 16'd2; wbuf[2] = 16'd3;
      send_burst(3, 2, -1);
      wbuf[0] = 16'd100; wbuf[1] = 16'd200; wbuf[2] = 16'hFFFF;
      send_burst(3, 2, -1);
      wait_drain();

      // Backpressure: ready low for three cycles at word 0
      ready_mode = 2;
      wbuf[0] = 16'd7; wbuf[1] = 16'd8;
      send_burst(2, 1, -1);
      chk("bp_hold_a", 32'(out_data), 32'(7));
      @(posedge clk); #1;
      chk("bp_hold_b", 32'(out_data), 32'(7));
      chk("bp_no_done", 32'(done), 32'(0));
      ready_mode = 0;
      out_ready  = 1'b1;
      wait_drain();

      // Rising complete during capture sets err but leaves samples intact
      for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
      send_burst(4, 1, 1);
      wait_drain();
      chk("err_sticky", 32'(err), 32'(1));
      do_flush();
      chk("flush_err_clr", 32'(err), 32'(0));

      // Illegal P at an IDLE edge
      pulse_edge(0);
      chk("p0_err", 32'(err), 32'(1));
      chk("p0_busy", 32'(busy), 32'(0));
      chk("p0_valid", 32'(out_valid), 32'(0));
      do_flush();
      pulse_edge(25);
      chk("p25_err", 32'(err), 32'(1));
      chk("p25_busy", 32'(busy), 32'(0));
      do_flush();

      // Flush in the middle of a drain
      ready_mode = 2;
      wbuf[0] = 16'd11; wbuf[1] = 16'd12; wbuf[2] = 16'd13;
      send_burst(3, 1, -1);
      ready_mode = 0;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      chk("flush_pre_idx", 32'(out_idx), 32'(1));
      do_flush();
      chk("flush_valid", 32'(out_valid), 32'(0));
      chk("flush_err", 32'(err), 32'(0));
      chk("flush_busy", 32'(busy), 32'(0));
      wbuf[0] = 16'd5; wbuf[1] = 16'd6;
      send_burst(2, 1, -1);
      wait_drain();

      // Reset in the middle of a capture with complete held high
      P = 5'd4; npass = 4'd1; complete = 1'b1; opsum = 16'($urandom);
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      rst_n = 1'b1;
      model_clear();
      repeat (4) begin @(posedge clk); #1; end
      chk("rst_no_edge_busy", 32'(busy), 32'(0));
      chk("rst_no_edge_err", 32'(err), 32'(0));
      chk("rst_no_edge_valid", 32'(out_valid), 32'(0));
      complete = 1'b0;
      @(posedge clk); #1;
      wbuf[0] = 16'd21; wbuf[1] = 16'd22; wbuf[2] = 16'd23;
      send_burst(3, 1, -1);
      wait_drain();

      // Randomized bursts, pass counts and ready patterns
      ready_mode = 1;
      for (int it = 0; it < 24; it++) begin
         int p, np, npe;
         p   = $urandom_range(1, 24);
         np  = $urandom_range(0, 3);
         npe = (np == 0) ? 1 : np;
         for (int ps = 0; ps < npe; ps++) begin
            for (int i = 0; i < 24; i++) wbuf[i] = 16'($urandom);
            send_burst(p, np, -1);
         end
         wait_drain();
      end
      ready_mode = 0;
      out_ready  = 1'b1;
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
